// File: rtl/gemm_dot_acc_pipe.sv
// gemm_dot_acc_pipe
//   Pipelined dot-product slice with group accumulation. Each accepted beat
//   carries LANES data/kernel pairs which are multiplied lane-wise (S1),
//   reduced by a registered adder tree (S2) and accumulated with saturation
//   (S3) until a beat marked in_last closes the group. The group result is
//   then held on a valid/ready output.
//
// Ports
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   in_valid / in_ready  input beat handshake (in_ready = global enable)
//   in_last              beat closes its accumulation group
//   in_data, kernel      packed operands, lane i = bits [i*DW +: DW]
//   out_valid/out_ready  result handshake
//   out_data             saturated group sum
//   out_beats            beats in the group, saturating at all-ones
//   out_ovf              accumulator clamped at least once in the group
module gemm_dot_acc_pipe #(
    parameter int LANES  = 32,
    parameter int DW     = 8,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic [LANES*DW-1:0] in_data,
    input  logic [LANES*DW-1:0] kernel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_data,
    output logic [CNT_W-1:0]    out_beats,
    output logic                out_ovf
);
    localparam int PW = 2 * DW;
    localparam int LG = $clog2(LANES);
    localparam int SW = PW + LG;
    // Accumulate in a width that holds both acc and s2_sum with headroom, so
    // the clamp is a plain signed range compare for either operand mode.
    localparam int XW = ((ACC_W > SW) ? ACC_W : SW) + 2;
    localparam logic [XW-1:0] ONE = XW'(1);
    localparam logic signed [XW-1:0] MAX_V =
        (SIGNED != 0) ? (ONE << (ACC_W - 1)) - ONE : (ONE << ACC_W) - ONE;
    localparam logic signed [XW-1:0] MIN_V =
        (SIGNED != 0) ? '0 - (ONE << (ACC_W - 1)) : '0;

    logic                 en;
    logic                 s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic [PW-1:0]        s1_prod_q [LANES];
    logic [PW-1:0]        s1_prod_d [LANES];
    logic                 s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic [SW-1:0]        s2_sum_q, s2_sum_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_W-1:0]     out_data_q, out_data_d;
    logic [CNT_W-1:0]     out_beats_q, out_beats_d;
    logic                 out_ovf_q, out_ovf_d;
    logic signed [XW-1:0] acc_x, add_x, sum_x;
    logic [ACC_W-1:0]     clamped;
    logic                 clamp;
    logic [CNT_W-1:0]     cnt_inc;
    logic [SW-1:0]        tree;

    // Low PW bits of the product are exact in both modes once the operands
    // are extended to PW bits according to their signedness.
    function automatic logic [PW-1:0] lane_mul(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        logic [PW-1:0] ax, bx;
        if (SIGNED != 0) begin
            ax = PW'($signed(a));
            bx = PW'($signed(b));
        end else begin
            ax = PW'(a);
            bx = PW'(b);
        end
        return ax * bx;
    endfunction

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    // S1: lane products
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_prod_d  = s1_prod_q;
        if (en) begin
            s1_valid_d = in_valid;
            s1_last_d  = in_last;
            if (in_valid) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    s1_prod_d[i] = lane_mul(in_data[i*DW +: DW], kernel[i*DW +: DW]);
                end
            end
        end
    end

    // S2: adder tree
    always_comb begin
        tree = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (SIGNED != 0) tree = tree + SW'($signed(s1_prod_q[i]));
            else             tree = tree + SW'(s1_prod_q[i]);
        end
        s2_valid_d = s2_valid_q;
        s2_last_d  = s2_last_q;
        s2_sum_d   = s2_sum_q;
        if (en) begin
            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
            if (s1_valid_q) s2_sum_d = tree;
        end
    end

    // S3: saturating accumulate and result register
    always_comb begin
        if (SIGNED != 0) begin
            acc_x = XW'($signed(acc_q));
            add_x = XW'($signed(s2_sum_q));
        end else begin
            acc_x = XW'(acc_q);
            add_x = XW'(s2_sum_q);
        end
        sum_x = acc_x + add_x;
        clamp = 1'b0;
        if (sum_x > MAX_V) begin
            clamped = MAX_V[ACC_W-1:0];
            clamp   = 1'b1;
        end else if (sum_x < MIN_V) begin
            clamped = MIN_V[ACC_W-1:0];
            clamp   = 1'b1;
        end else begin
            clamped = sum_x[ACC_W-1:0];
        end
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_beats_d = out_beats_q;
        out_ovf_d   = out_ovf_q;
        if (en && s2_valid_q) begin
            if (s2_last_q) begin
                out_valid_d = 1'b1;
                out_data_d  = clamped;
                out_beats_d = cnt_inc;
                out_ovf_d   = ovf_q | clamp;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d = clamped;
                cnt_d = cnt_inc;
                ovf_d = ovf_q | clamp;
            end
        end
    end

    always_ff @(posedge clk) begin
        s1_prod_q <= s1_prod_d;
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_sum_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_beats_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s2_sum_q    <= s2_sum_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_beats_q <= out_beats_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_beats = out_beats_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_gemm_dot_acc_pipe.sv
// Testbench for gemm_dot_acc_pipe: an unsigned (ACC_W=32) and a signed
// (ACC_W=20, CNT_W=4) instance share one input stream and are checked against
// a group-level accumulation model plus hand-computed expectations.
module tb_gemm_dot_acc_pipe;
    localparam int LANES  = 32;
    localparam int DW     = 8;
    localparam int ACCW_U = 32;
    localparam int CNTW_U = 16;
    localparam int ACCW_S = 20;
    localparam int CNTW_S = 4;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_last, out_ready;
    logic [LANES*DW-1:0] in_data, kernel;
    logic in_ready_u, out_valid_u, out_ovf_u;
    logic [ACCW_U-1:0] out_data_u;
    logic [CNTW_U-1:0] out_beats_u;
    logic in_ready_s, out_valid_s, out_ovf_s;
    logic [ACCW_S-1:0] out_data_s;
    logic [CNTW_S-1:0] out_beats_s;

    int total = 0;
    int bad   = 0;

    typedef struct { longint data; longint beats; bit ovf; } res_t;
    res_t   q_u[$];
    res_t   q_s[$];
    longint acc_u = 0, cnt_u = 0, acc_s = 0, cnt_s = 0;
    bit     ovf_u = 1'b0, ovf_s = 1'b0;

    always #5 clk = ~clk;

    gemm_dot_acc_pipe #(.LANES(LANES), .DW(DW), .ACC_W(ACCW_U), .SIGNED(0), .CNT_W(CNTW_U)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_last(in_last), .in_data(in_data), .kernel(kernel),
        .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u),
        .out_beats(out_beats_u), .out_ovf(out_ovf_u));

    gemm_dot_acc_pipe #(.LANES(LANES), .DW(DW), .ACC_W(ACCW_S), .SIGNED(1), .CNT_W(CNTW_S)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_last(in_last), .in_data(in_data), .kernel(kernel),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_beats(out_beats_s), .out_ovf(out_ovf_s));

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string why);
        total++;
        bad++;
        $display("FAIL %s: %s", name, why);
    endtask

    function automatic longint beat_sum(input bit sgn);
        longint s = 0;
        logic [DW-1:0] a, b;
        for (int i = 0; i < LANES; i++) begin
            a = in_data[i*DW +: DW];
            b = kernel[i*DW +: DW];
            if (sgn) s += longint'($signed(a)) * longint'($signed(b));
            else     s += longint'(a) * longint'(b);
        end
        return s;
    endfunction

    task automatic model_beat(input bit sgn, input int accw, input int cntw,
                              inout longint acc, inout longint cnt, inout bit ovf);
        longint one = 1;
        longint v, hi, lo;
        v  = acc + beat_sum(sgn);
        hi = sgn ? (one << (accw - 1)) - 1 : (one << accw) - 1;
        lo = sgn ? -(one << (accw - 1)) : 0;
        if (v > hi) begin v = hi; ovf = 1'b1; end
        else if (v < lo) begin v = lo; ovf = 1'b1; end
        acc = v;
        if (cnt < (one << cntw) - 1) cnt = cnt + 1;
    endtask

    // Unsigned instance: output check, then model update for this cycle's beat
    always @(negedge clk) begin
        res_t r;
        if (!rst_n) begin
            q_u.delete();
            acc_u = 0; cnt_u = 0; ovf_u = 1'b0;
        end else begin
            if (out_valid_u) begin
                if (q_u.size() == 0) flag("u_unexpected", "result with no group closed");
                else begin
                    check("u_data",  longint'(out_data_u),  q_u[0].data);
                    check("u_beats", longint'(out_beats_u), q_u[0].beats);
                    check("u_ovf",   longint'(out_ovf_u),   longint'(q_u[0].ovf));
                    if (out_ready) void'(q_u.pop_front());
                end
            end
            if (in_valid && in_ready_u) begin
                model_beat(1'b0, ACCW_U, CNTW_U, acc_u, cnt_u, ovf_u);
                if (in_last) begin
                    r.data = acc_u; r.beats = cnt_u; r.ovf = ovf_u;
                    q_u.push_back(r);
                    acc_u = 0; cnt_u = 0; ovf_u = 1'b0;
                end
            end
        end
    end

    // Signed instance
    always @(negedge clk) begin
        res_t r;
        if (!rst_n) begin
            q_s.delete();
            acc_s = 0; cnt_s = 0; ovf_s = 1'b0;
        end else begin
            if (out_valid_s) begin
                if (q_s.size() == 0) flag("s_unexpected", "result with no group closed");
                else begin
                    check("s_data",  longint'($signed(out_data_s)), q_s[0].data);
                    check("s_beats", longint'(out_beats_s),         q_s[0].beats);
                    check("s_ovf",   longint'(out_ovf_s),           longint'(q_s[0].ovf));
                    if (out_ready) void'(q_s.pop_front());
                end
            end
            if (in_valid && in_ready_s) begin
                model_beat(1'b1, ACCW_S, CNTW_S, acc_s, cnt_s, ovf_s);
                if (in_last) begin
                    r.data = acc_s; r.beats = cnt_s; r.ovf = ovf_s;
                    q_s.push_back(r);
                    acc_s = 0; cnt_s = 0; ovf_s = 1'b0;
                end
            end
        end
    end

    // All driving tasks start and return just after a rising edge.
    task automatic send_beat(input logic [DW-1:0] d, input logic [DW-1:0] k, input bit last);
        bit ok = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            in_data[i*DW +: DW] = d;
            kernel[i*DW +: DW]  = k;
        end
        in_valid = 1'b1;
        in_last  = last;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (in_ready_u) ok = 1'b1;
        end
        if (!ok) flag("send_timeout", "in_ready never rose");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_hs(output longint du, output longint bu, output longint ou,
                           output longint ds, output longint bs, output longint os,
                           output int n);
        bit hit = 1'b0;
        n = 0;
        du = -1; bu = -1; ou = -1; ds = -1; bs = -1; os = -1;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            n++;
            if (out_valid_u && out_ready) begin
                hit = 1'b1;
                du = longint'(out_data_u);
                bu = longint'(out_beats_u);
                ou = longint'(out_ovf_u);
                ds = longint'($signed(out_data_s));
                bs = longint'(out_beats_s);
                os = longint'(out_ovf_s);
            end
        end
        if (!hit) flag("result_timeout", "no output handshake");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint du, bu, ou, ds, bs, os;
        longint got[4];
        int lat;

        // Reset with a beat on the inputs
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            in_data[i*DW +: DW] = DW'($urandom_range(255));
            kernel[i*DW +: DW]  = DW'($urandom_range(255));
        end
        repeat (2) begin
            @(negedge clk);
            check("rst_in_ready",  longint'(in_ready_u),  1);
            check("rst_out_valid", longint'(out_valid_u), 0);
            check("rst_out_data",  longint'(out_data_u),  0);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;

        // Single-beat group
        send_beat(8'd3, 8'd5, 1'b1);
        wait_hs(du, bu, ou, ds, bs, os, lat);
        check("single_latency", lat, 3);
        check("single_u_data",  du, 480);
        check("single_u_beats", bu, 1);
        check("single_u_ovf",   ou, 0);
        check("single_s_data",  ds, 480);

        // Four beats with two bubbles between them
        for (int k = 0; k < 4; k++) begin
            send_beat(DW'(k + 1), 8'd1, k == 3);
            if (k < 3) repeat (2) begin @(posedge clk); #1; end
        end
        wait_hs(du, bu, ou, ds, bs, os, lat);
        check("bubbles_latency", lat, 3);
        check("bubbles_u_data",  du, 320);
        check("bubbles_u_beats", bu, 4);
        check("bubbles_s_beats", bs, 4);

        // Backpressure: three groups while the sink is stalled, a fourth offered
        // while in_ready is low
        out_ready = 1'b0;
        send_beat(8'd1, 8'd1, 1'b1);
        send_beat(8'd2, 8'd1, 1'b1);
        send_beat(8'd3, 8'd1, 1'b1);
        @(negedge clk);
        check("bp_out_valid", longint'(out_valid_u), 1);
        check("bp_in_ready",  longint'(in_ready_u),  0);
        @(posedge clk);
        #1;
        fork
            send_beat(8'd4, 8'd1, 1'b1);
            begin
                repeat (2) begin @(posedge clk); #1; end
                out_ready = 1'b1;
            end
            for (int j = 0; j < 4; j++) begin
                wait_hs(du, bu, ou, ds, bs, os, lat);
                got[j] = du;
            end
        join
        check("bp_res0", got[0], 32);
        check("bp_res1", got[1], 64);
        check("bp_res2", got[2], 96);
        check("bp_res3", got[3], 128);

        // Positive saturation: 40 beats of (-128)*(-128) per lane
        for (int k = 0; k < 40; k++) send_beat(8'h80, 8'h80, k == 39);
        wait_hs(du, bu, ou, ds, bs, os, lat);
        check("satp_u_data",  du, 20971520);
        check("satp_u_beats", bu, 40);
        check("satp_u_ovf",   ou, 0);
        check("satp_s_data",  ds, 524287);
        check("satp_s_ovf",   os, 1);
        check("satp_s_beats", bs, 15);
        send_beat(8'd0, 8'd0, 1'b1);
        wait_hs(du, bu, ou, ds, bs, os, lat);
        check("zero_s_data",  ds, 0);
        check("zero_s_ovf",   os, 0);
        check("zero_s_beats", bs, 1);

        // Negative saturation: 2 beats of (-128)*127 per lane
        send_beat(8'h80, 8'h7F, 1'b0);
        send_beat(8'h80, 8'h7F, 1'b1);
        wait_hs(du, bu, ou, ds, bs, os, lat);
        check("satn_u_data", du, 1040384);
        check("satn_s_data", ds, -524288);
        check("satn_s_ovf",  os, 1);

        // Reset in the middle of a group
        send_beat(8'd7, 8'd7, 1'b0);
        send_beat(8'd7, 8'd7, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_beat(8'd1, 8'd1, 1'b1);
        wait_hs(du, bu, ou, ds, bs, os, lat);
        check("midrst_u_data",  du, 32);
        check("midrst_u_beats", bu, 1);
        check("midrst_s_data",  ds, 32);

        repeat (5) @(posedge clk);
        #1;
        check("u_pending", q_u.size(), 0);
        check("s_pending", q_s.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
